// File: rtl/serial_frame_rx_pkg.sv
// Shared encodings for the serial frame link (receiver and matching transmitter).
package serial_frame_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SR_HOLD  = 2'd0,
        SR_RIGHT = 2'd1,
        SR_LEFT  = 2'd2,
        SR_CLEAR = 2'd3
    } sr_mode_e;

    // 0 = even parity, 1 = odd parity; XORed into the parity check.
    localparam logic PARITY_MODE = 1'b0;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Serial link bundle: bit stream toward the receiver, reassembled word and flags back.
interface serial_frame_rx_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_vld;
    logic             msb_first;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic             perr;
    logic             ferr;
    logic             busy;

    modport master (
        output sin, sin_vld, msb_first,
        input  dout, dout_vld, perr, ferr, busy
    );

    modport slave (
        input  sin, sin_vld, msb_first,
        output dout, dout_vld, perr, ferr, busy
    );
endinterface

// File: rtl/serial_frame_rx_shift_reg.sv
// Universal shift register (hold / shift-right-in / shift-left-in / clear), same shape as the transmitter's.
module rx_shift_reg
    import serial_frame_rx_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  sr_mode_e         mode_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            case (mode_i)
                SR_RIGHT: q_q <= {sin_i, q_q[WIDTH-1:1]};
                SR_LEFT:  q_q <= {q_q[WIDTH-2:0], sin_i};
                SR_CLEAR: q_q <= '0;
                default:  q_q <= q_q;
            endcase
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start, WIDTH data bits, optional parity, stop; word out with valid pulse and error flags.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_frame_rx_if.slave    rx
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             msb_q;
    logic             par_q;
    logic             perr_pend_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_vld_q;
    logic             perr_q;
    logic             ferr_q;
    logic [WIDTH-1:0] sr;
    sr_mode_e         sr_mode_d;

    always_comb begin
        sr_mode_d = SR_HOLD;
        if (rx.sin_vld) begin
            if (state_q == IDLE && !rx.sin) sr_mode_d = SR_CLEAR;
            else if (state_q == DATA)       sr_mode_d = msb_q ? SR_LEFT : SR_RIGHT;
        end
    end

    rx_shift_reg #(.WIDTH(WIDTH)) u_sr (
        .clk    (clk),
        .rst_n  (rst_n),
        .mode_i (sr_mode_d),
        .sin_i  (rx.sin),
        .q_o    (sr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            msb_q       <= 1'b0;
            par_q       <= 1'b0;
            perr_pend_q <= 1'b0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            // Pulses self-clear even while the strobe is idle.
            dout_vld_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            if (rx.sin_vld) begin
                case (state_q)
                    IDLE: if (!rx.sin) begin
                        state_q     <= DATA;
                        cnt_q       <= '0;
                        msb_q       <= rx.msb_first;
                        par_q       <= 1'b0;
                        perr_pend_q <= 1'b0;
                    end
                    DATA: begin
                        par_q <= par_q ^ rx.sin;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1))
                            state_q <= PARITY_EN ? PARITY : STOP;
                    end
                    PARITY: begin
                        perr_pend_q <= par_q ^ rx.sin ^ PARITY_MODE;
                        state_q     <= STOP;
                    end
                    default: begin
                        // A low stop bit is a framing error, never a new start bit.
                        if (rx.sin) begin
                            dout_q     <= sr;
                            dout_vld_q <= 1'b1;
                            perr_q     <= perr_pend_q;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rx.dout     = dout_q;
    assign rx.dout_vld = dout_vld_q;
    assign rx.perr     = perr_q;
    assign rx.ferr     = ferr_q;
    assign rx.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (WIDTH=4, even parity enabled).
module tb_serial_frame_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    serial_frame_rx_if #(.WIDTH(4)) bus ();

    serial_frame_rx #(.WIDTH(4), .PARITY_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (bus.slave)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one strobed bit; returns #1 after the sampling edge with the strobe dropped.
    task automatic send_bit(input logic b);
        bus.sin     = b;
        bus.sin_vld = 1'b1;
        @(posedge clk);
        #1;
        bus.sin_vld = 1'b0;
        bus.sin     = 1'b1;
    endtask

    // Idle cycles between bits; state must not move and no pulse may appear.
    task automatic gap(input int n, input logic [3:0] dout_exp);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("gap_busy", 16'(bus.busy), 16'd1);
            chk("gap_vld", 16'(bus.dout_vld), 16'd0);
            chk("gap_dout", 16'(bus.dout), 16'(dout_exp));
        end
    endtask

    // bits[0] is transmitted first. msb_first is flipped after the start bit to prove it is latched.
    task automatic send_frame(input logic msb, input logic [3:0] bits, input logic par,
                              input logic stop, input int g, input logic [3:0] dout_old);
        bus.msb_first = msb;
        send_bit(1'b0);
        chk("start_busy", 16'(bus.busy), 16'd1);
        bus.msb_first = ~msb;
        for (int i = 0; i < 4; i++) begin
            if (g > 0) gap(g, dout_old);
            send_bit(bits[i]);
        end
        if (g > 0) gap(g, dout_old);
        send_bit(par);
        if (g > 0) gap(g, dout_old);
        send_bit(stop);
    endtask

    initial begin
        bus.sin       = 1'b1;
        bus.sin_vld   = 1'b0;
        bus.msb_first = 1'b0;

        // 1: reset, then idle-high strobes
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_dout", 16'(bus.dout), 16'h0);
        rst_n = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("idle_busy", 16'(bus.busy), 16'd0);
        chk("idle_dout", 16'(bus.dout), 16'h0);
        chk("idle_vld", 16'(bus.dout_vld), 16'd0);
        chk("idle_ferr", 16'(bus.ferr), 16'd0);

        // 2: LSB-first 1010
        send_frame(1'b0, 4'b1010, 1'b0, 1'b1, 0, 4'h0);
        chk("t2_vld", 16'(bus.dout_vld), 16'd1);
        chk("t2_dout", 16'(bus.dout), 16'hA);
        chk("t2_perr", 16'(bus.perr), 16'd0);
        chk("t2_ferr", 16'(bus.ferr), 16'd0);
        chk("t2_busy", 16'(bus.busy), 16'd0);

        // 3: MSB-first 0011, back-to-back start on the next strobe
        send_frame(1'b1, 4'b1100, 1'b0, 1'b1, 0, 4'hA);
        chk("t3a_vld", 16'(bus.dout_vld), 16'd1);
        chk("t3a_dout", 16'(bus.dout), 16'h3);
        chk("t3a_perr", 16'(bus.perr), 16'd0);
        bus.msb_first = 1'b1;
        send_bit(1'b0);
        chk("t3b_vld_drop", 16'(bus.dout_vld), 16'd0);
        chk("t3b_busy", 16'(bus.busy), 16'd1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("t3b_vld", 16'(bus.dout_vld), 16'd1);
        chk("t3b_dout", 16'(bus.dout), 16'h3);
        chk("t3b_perr", 16'(bus.perr), 16'd1);
        @(posedge clk);
        #1;
        chk("t3b_perr_drop", 16'(bus.perr), 16'd0);
        chk("t3b_vld_drop2", 16'(bus.dout_vld), 16'd0);

        // 4: bad stop bit, then LSB-first 1100
        send_frame(1'b0, 4'b1111, 1'b0, 1'b0, 0, 4'h3);
        chk("t4_ferr", 16'(bus.ferr), 16'd1);
        chk("t4_vld", 16'(bus.dout_vld), 16'd0);
        chk("t4_dout", 16'(bus.dout), 16'h3);
        chk("t4_busy", 16'(bus.busy), 16'd0);
        @(posedge clk);
        #1;
        chk("t4_ferr_drop", 16'(bus.ferr), 16'd0);
        chk("t4_idle_busy", 16'(bus.busy), 16'd0);
        send_frame(1'b0, 4'b1100, 1'b0, 1'b1, 0, 4'h3);
        chk("t4b_vld", 16'(bus.dout_vld), 16'd1);
        chk("t4b_dout", 16'(bus.dout), 16'hC);
        chk("t4b_perr", 16'(bus.perr), 16'd0);

        // 5: 1111 with 3-cycle strobe gaps
        send_frame(1'b0, 4'b1111, 1'b0, 1'b1, 3, 4'hC);
        chk("t5_vld", 16'(bus.dout_vld), 16'd1);
        chk("t5_dout", 16'(bus.dout), 16'hF);
        chk("t5_perr", 16'(bus.perr), 16'd0);
        @(posedge clk);
        #1;

        // 6: reset after two data bits, then a clean 1010
        bus.msb_first = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("t6_busy_pre", 16'(bus.busy), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 16'(bus.busy), 16'd0);
        chk("t6_dout", 16'(bus.dout), 16'h0);
        chk("t6_vld", 16'(bus.dout_vld), 16'd0);
        chk("t6_ferr", 16'(bus.ferr), 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(1'b0, 4'b1010, 1'b0, 1'b1, 0, 4'h0);
        chk("t6b_vld", 16'(bus.dout_vld), 16'd1);
        chk("t6b_dout", 16'(bus.dout), 16'hA);
        chk("t6b_perr", 16'(bus.perr), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
Serial-to-parallel receiver: the far end of the team's 4-bit universal shift-register transmitter link. Accepts a framed serial bit stream, one bit per qualified clock: start bit, WIDTH data bits, optional even parity, stop bit. Reassembles the parallel word with a selectable shift direction (LSB-first = shift-right fill, MSB-first = shift-left fill). Presents the word with a one-cycle valid pulse and error flags.

Parameters:
WIDTH, 4, data bits per frame (2..16).
PARITY_EN, 1, 1 = even parity bit follows the data; 0 = no parity bit.

Ports:
clk  in  1  single system clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
sin  in  1  serial data; idles high.
sin_vld  in  1  bit strobe; sin is sampled only on edges where sin_vld=1.
msb_first  in  1  0 = LSB-first, 1 = MSB-first; sampled on the start bit, held for the frame.
dout  out  WIDTH  last accepted word; held until the next accepted frame.
dout_vld  out  1  one-cycle pulse when dout updates.
perr  out  1  parity error; valid with dout_vld, 0 otherwise.
ferr  out  1  one-cycle pulse on a bad stop bit.
busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, bit counter=0, shift register=0, dout=0, dout_vld=0, perr=0, ferr=0, busy=0. Reset mid-frame aborts the frame with no output pulse.
- The FSM advances only on sin_vld=1 edges; sin_vld=0 holds all state (hold mode). dout_vld/ferr still drop to 0 one cycle after pulsing.
- IDLE: sin_vld&&sin==0 -> DATA; counter=0, latch msb_first, clear shift reg, running parity=0. sin==1 stays IDLE.
- DATA: each strobe shifts sin in. LSB-first: sr={sin, sr[WIDTH-1:1]}. MSB-first: sr={sr[WIDTH-2:0], sin}. parity^=sin; counter++. After the WIDTH-th bit -> PARITY if PARITY_EN else STOP.
- PARITY: on strobe, perr_pending = parity^sin (even parity: total ones over data+parity must be even) -> STOP.
- STOP: on strobe, sin==1 -> dout<=sr, dout_vld=1, perr=perr_pending on the next cycle, then IDLE. sin==0 -> ferr=1 for one cycle, dout unchanged, no dout_vld, then IDLE. A 0 stop bit is not treated as a new start bit.
- Latency: dout/dout_vld are registered and appear on the clock edge that samples the stop bit. Visible in the cycle after that edge.
- Back-to-back frames: a start bit on the strobe immediately following the stop strobe is accepted. dout_vld of the prior frame and the new start coexist.
- Counter width is clog2(WIDTH+1). It wraps only by returning to IDLE, never arithmetically.
- busy=1 from the edge after the start bit through the stop-bit edge.

Decomposition:
- Shared header/package: state encodings (IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3) and the parity mode constant, reused by the matching transmitter.
- One sub-module: rx_shift_reg (WIDTH, mode input {hold, shift-right-in, shift-left-in, clear}, async active-low reset). This mirrors the transmitter's universal register. The FSM, counter, parity and output registers stay in serial_frame_rx.

Test Plan:
1. Reset, sin=1 with strobes -> busy=0, dout=0000, no pulses.
2. LSB-first, WIDTH=4, PARITY_EN=1, continuous strobes, bits 0|0,1,0,1|0|1 -> dout=1010, dout_vld one cycle, perr=0, ferr=0.
3. MSB-first frame 0|0,0,1,1|0|1 -> dout=0011, perr=0. Repeat with parity bit 1 -> dout=0011, dout_vld=1, perr=1.
4. LSB-first frame 0|1,1,1,1|0|0 (bad stop) -> ferr pulses once, dout keeps previous 0011, no dout_vld, next frame 0|0,0,1,1|0|1 gives dout=1100.
5. Frame for 1111 with sin_vld=0 for 3 cycles between every bit -> same result as continuous (dout=1111); no state change during gaps.
6. Assert rst_n=0 after 2 data bits -> immediate IDLE, all outputs 0. A following full frame for 1010 -> dout=1010 correctly.
